// File: rtl/layer_ringbuf_pkg.sv
// Shared types and sizing helpers for the per-layer circular input-vector store.
package layer_ringbuf_pkg;

    localparam int ID_BITS = 32;

    typedef logic [ID_BITS-1:0] id_t;

    function automatic int ptr_bits(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/layer_ringbuf_ctl.sv
// Pointer, occupancy and handshake control for layer_ringbuf_hs: accept decisions,
// non-power-of-2 wrap and the sticky ovf/unf/id_err flags.
module layer_ringbuf_ctl
    import layer_ringbuf_pkg::*;
#(
    parameter int depth = 2
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic                         id_mismatch,
    output logic [ptr_bits(depth)-1:0]   wr_ptr,
    output logic [ptr_bits(depth)-1:0]   rd_ptr,
    output logic                         push,
    output logic                         pop,
    output logic [cnt_bits(depth)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic                         unf,
    output logic                         id_err
);

    localparam int PW = ptr_bits(depth);
    localparam int CW = cnt_bits(depth);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;
    logic          r_id_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == CW'(depth));
    assign w_empty = (r_count == '0);
    // A pop on a full buffer frees its slot in the same cycle, so the push rides along.
    assign w_push  = wr_en & (~w_full | rd_en);
    assign w_pop   = rd_en & ~w_empty;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_id_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr_en & w_full & ~rd_en) r_ovf    <= 1'b1;
            if (rd_en & w_empty)         r_unf    <= 1'b1;
            if (w_pop & id_mismatch)     r_id_err <= 1'b1;
        end
    end

    assign wr_ptr = r_wr_ptr;
    assign rd_ptr = r_rd_ptr;
    assign push   = w_push;
    assign pop    = w_pop;
    assign count  = r_count;
    assign full   = w_full;
    assign empty  = w_empty;
    assign ovf    = r_ovf;
    assign unf    = r_unf;
    assign id_err = r_id_err;

endmodule

// File: rtl/layer_ringbuf_hs.sv
// Circular FIFO of ID-tagged input vectors between computation layer C_j and prover P_j.
// Define LAYER_RINGBUF_IDCHK_EN to flag stored-ID vs expected-ID mismatches on pops.
`ifndef F_NBITS
`define F_NBITS 32
`endif

module layer_ringbuf_hs
    import layer_ringbuf_pkg::*;
#(
    parameter int ninputs   = 8,
    parameter int layer_num = 0,
    parameter int depth     = 2 * (layer_num + 1),
    parameter int nbits     = `F_NBITS
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         wr_en,
    input  logic [nbits*ninputs-1:0]     v_in,
    input  logic [ID_BITS-1:0]           id_c_in,
    output logic                         full,
    input  logic                         rd_en,
    input  logic [ID_BITS-1:0]           id_p_in,
    output logic [nbits*ninputs-1:0]     v_out,
    output logic [ID_BITS-1:0]           id_p_out,
    output logic                         rd_valid,
    output logic                         empty,
    output logic [cnt_bits(depth)-1:0]   count,
    output logic                         ovf,
    output logic                         unf,
    output logic                         id_err
);

    localparam int PW = ptr_bits(depth);

    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_rd_ptr;
    logic          w_push;
    logic          w_pop;
    logic          w_id_mismatch;

    id_t           r_id_mem [depth];
    id_t           r_id_p_out;
    logic          r_rd_valid;

    layer_ringbuf_ctl #(.depth(depth)) u_ctl (
        .clk         (clk),
        .rstb        (rstb),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .id_mismatch (w_id_mismatch),
        .wr_ptr      (w_wr_ptr),
        .rd_ptr      (w_rd_ptr),
        .push        (w_push),
        .pop         (w_pop),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .ovf         (ovf),
        .unf         (unf),
        .id_err      (id_err)
    );

    // One storage array per field word; a same-cycle write to the popped slot returns old data.
    genvar gi;
    generate
        for (gi = 0; gi < ninputs; gi++) begin : g_word
            logic [nbits-1:0] r_mem [depth];
            logic [nbits-1:0] r_word_out;

            always_ff @(posedge clk) begin
                if (w_push) r_mem[w_wr_ptr] <= v_in[gi*nbits +: nbits];
            end

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb)      r_word_out <= '0;
                else if (w_pop) r_word_out <= r_mem[w_rd_ptr];
            end

            assign v_out[gi*nbits +: nbits] = r_word_out;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) r_id_mem[w_wr_ptr] <= id_c_in;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_id_p_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) r_id_p_out <= r_id_mem[w_rd_ptr];
        end
    end

`ifdef LAYER_RINGBUF_IDCHK_EN
    assign w_id_mismatch = (r_id_mem[w_rd_ptr] != id_p_in);
`else
    logic w_unused_id;
    assign w_unused_id   = ^id_p_in;
    assign w_id_mismatch = 1'b0;
`endif

    assign id_p_out = r_id_p_out;
    assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_layer_ringbuf_hs.sv
// Randomized and directed bench for layer_ringbuf_hs against a queue-based FIFO model.
module tb_layer_ringbuf_hs;

    localparam int D  = 4;
    localparam int NI = 2;
    localparam int NB = 16;
    localparam int W  = NB * NI;

    logic          clk;
    logic          rstb;
    logic          wr_en;
    logic [W-1:0]  v_in;
    logic [31:0]   id_c_in;
    logic          full;
    logic          rd_en;
    logic [31:0]   id_p_in;
    logic [W-1:0]  v_out;
    logic [31:0]   id_p_out;
    logic          rd_valid;
    logic          empty;
    logic [2:0]    count;
    logic          ovf;
    logic          unf;
    logic          id_err;

    layer_ringbuf_hs #(.ninputs(NI), .layer_num(1), .depth(D), .nbits(NB)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .wr_en    (wr_en),
        .v_in     (v_in),
        .id_c_in  (id_c_in),
        .full     (full),
        .rd_en    (rd_en),
        .id_p_in  (id_p_in),
        .v_out    (v_out),
        .id_p_out (id_p_out),
        .rd_valid (rd_valid),
        .empty    (empty),
        .count    (count),
        .ovf      (ovf),
        .unf      (unf),
        .id_err   (id_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic run_chk = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: an ordered queue of (vector, id) plus the registered read view.
    typedef struct packed {
        logic [W-1:0] v;
        logic [31:0]  id;
    } ent_t;

    ent_t         q[$];
    logic         m_valid, m_ovf, m_unf, m_err;
    logic [W-1:0] m_v;
    logic [31:0]  m_id;

    always @(posedge clk or negedge rstb) begin
        int   sz;
        ent_t e;
        if (!rstb) begin
            q.delete();
            m_valid = 0; m_ovf = 0; m_unf = 0; m_err = 0;
            m_v = '0; m_id = '0;
        end else begin
            sz = q.size();
            m_valid = 0;
            if (wr_en && sz == D && !rd_en) m_ovf = 1;
            if (rd_en && sz == 0) m_unf = 1;
            if (rd_en && sz > 0) begin
                e = q.pop_front();
                m_valid = 1;
                m_v = e.v;
                m_id = e.id;
`ifdef LAYER_RINGBUF_IDCHK_EN
                if (e.id != id_p_in) m_err = 1;
`endif
            end
            if (wr_en && (sz < D || rd_en)) begin
                e.v = v_in;
                e.id = id_c_in;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk && rstb) begin
            chk("count",    count,    q.size());
            chk("full",     full,     q.size() == D);
            chk("empty",    empty,    q.size() == 0);
            chk("rd_valid", rd_valid, m_valid);
            chk("v_out",    v_out,    m_v);
            chk("id_p_out", id_p_out, m_id);
            chk("ovf",      ovf,      m_ovf);
            chk("unf",      unf,      m_unf);
            chk("id_err",   id_err,   m_err);
        end
    end

    function automatic logic [31:0] front_id();
        return (q.size() > 0) ? q[0].id : 32'd0;
    endfunction

    task automatic cyc(input logic wr, input logic [31:0] id, input logic rd, input logic [31:0] idp);
        logic [NB-1:0] hi;
        hi = NB'($urandom);
        wr_en = wr; id_c_in = id; v_in = {hi, id[NB-1:0]};
        rd_en = rd; id_p_in = idp;
        $display("cyc wr=%0d id=%0d rd=%0d idp=%0d", wr, id, rd, idp);
        @(negedge clk);
        wr_en = 0; rd_en = 0;
    endtask

    initial begin
        rstb = 1'b1; wr_en = 0; rd_en = 0; v_in = '0; id_c_in = '0; id_p_in = '0;
        #1 rstb = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_v_out", v_out, 0);
        chk("rst_flags", {ovf, unf, id_err}, 0);
        rstb = 1'b1;
        run_chk = 1'b1;

        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0);
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 1, i);
            chk("drain_valid", rd_valid, 1);
            chk("drain_id", id_p_out, i);
            chk("drain_word0", v_out[NB-1:0], i);
        end
        chk("drain_empty", empty, 1);
        cyc(0, 0, 0, 0);
        chk("idle_valid", rd_valid, 0);

        for (int k = 0; k < 3; k++) begin
            cyc(1, 11 + 2 * k, 0, 0);
            cyc(1, 12 + 2 * k, 0, 0);
            cyc(0, 0, 1, front_id());
        end
        repeat (3) cyc(0, 0, 1, front_id());
        chk("wrap_last_id", id_p_out, 16);

        for (int i = 21; i <= 24; i++) cyc(1, i, 0, 0);
        cyc(1, 9, 0, 0);
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, 4);
        cyc(0, 0, 1, front_id());
        chk("ovf_oldest", id_p_out, 21);

        cyc(1, 25, 0, 0);
        chk("refill_full", full, 1);
        cyc(1, 10, 1, front_id());
        chk("pushpop_count", count, 4);
        chk("pushpop_id", id_p_out, 22);
        repeat (4) cyc(0, 0, 1, front_id());
        chk("pushpop_last", id_p_out, 10);
        chk("pushpop_empty", empty, 1);

        cyc(0, 0, 1, 0);
        chk("unf_set", unf, 1);
        chk("unf_valid", rd_valid, 0);
        cyc(1, 5, 0, 0);
        cyc(0, 0, 1, 6);
        chk("idchk_id", id_p_out, 5);
`ifdef LAYER_RINGBUF_IDCHK_EN
        chk("idchk_err", id_err, 1);
`else
        chk("idchk_err", id_err, 0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [31:0] idp;
            idp = front_id();
            if ($urandom_range(0, 15) == 0) idp = ~idp;
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), idp);
        end

        repeat (5) cyc(0, 0, 1, front_id());
        for (int i = 31; i <= 33; i++) cyc(1, i, 0, 0);
        chk("pre_rst_count", count, 3);
        #2 rstb = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_v_out", v_out, 0);
        chk("mid_rst_id", id_p_out, 0);
        chk("mid_rst_flags", {ovf, unf, id_err}, 0);
        @(negedge clk);
        rstb = 1'b1;
        cyc(1, 7, 0, 0);
        cyc(0, 0, 1, 7);
        chk("post_rst_id", id_p_out, 7);
        chk("post_rst_valid", rd_valid, 1);
        chk("post_rst_word0", v_out[NB-1:0], 7);
        cyc(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
